data_output_tx: RTL and testbench
=================================

Name: data_output_tx

Overview:
- GPIO-side transmitter for the 8-bit coordinate/value link; the counterpart of the FPGA receiver that splits a byte into COORD[7:3], VALUE[2:1] and parity[0].
- Accepts (coord, value) updates from internal logic and buffers them in a small FIFO.
- Serialises updates as strobed bytes: data set up, then ENABLE held high, then a gap.
- The far end writes exactly once per rising edge of ENABLE.

Parameters:
- SETUP_CYCLES, 2, cycles DATA_OUT is stable before ENABLE_OUT rises (min 1)
- HOLD_CYCLES, 4, cycles ENABLE_OUT stays high (min 1)
- GAP_CYCLES, 4, cycles ENABLE_OUT stays low, with DATA_OUT held, before the next frame (min 1)
- FIFO_DEPTH, 4, FIFO entries (power of 2, min 2)
- CNT_W, 8, timing counter width (must hold max(SETUP,HOLD,GAP)-1)

Ports:
- CLOCK_50  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- COORD_IN  in  5  grid coordinate to send
- VALUE_IN  in  2  cell value to send
- WRITE_IN  in  1  push request; sampled each cycle
- FULL  out  1  FIFO holds FIFO_DEPTH entries
- OVERFLOW  out  1  one-cycle pulse when a push is dropped
- BUSY  out  1  high whenever state != IDLE or the FIFO is non-empty
- DATA_OUT  out  8  {coord[4:0], value[1:0], parity} to GPIO
- ENABLE_OUT  out  1  write strobe to GPIO

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET is synchronous and active-high.
- Reset values: DATA_OUT=0, ENABLE_OUT=0, FULL=0, OVERFLOW=0, BUSY=0, FIFO empty, state IDLE, counter 0.
- Reset mid-frame: ENABLE_OUT goes low on the next edge and queued entries are discarded.
- Push rule:
  - WRITE_IN=1 and FULL=0: entry stored at the edge.
  - WRITE_IN=1 and FULL=1: entry dropped; OVERFLOW=1 for the following cycle only.
  - FULL is registered from the occupancy count.
- Simultaneous push and pop: both take effect; occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy count is log2(FIFO_DEPTH)+1 bits.
- Byte format: DATA_OUT[7:3]=coord, [2:1]=value, [0]=XOR of bits [7:1]. Parity is even: the XOR of all 8 bits is 0.
- FSM (counter reloads on each transition):
  - IDLE: ENABLE_OUT=0. If the FIFO is non-empty, pop, register the byte into DATA_OUT, and go to SETUP.
  - SETUP: ENABLE_OUT=0 for SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: ENABLE_OUT=1 for HOLD_CYCLES cycles, then go to GAP.
  - GAP: ENABLE_OUT=0 for GAP_CYCLES cycles, then go to IDLE.
- Timing for a push at edge 0 into an empty, idle block:
  - DATA_OUT updates after edge 1.
  - ENABLE_OUT rises after edge 1+SETUP_CYCLES.
  - ENABLE_OUT falls after edge 1+SETUP_CYCLES+HOLD_CYCLES.
  - State returns to IDLE after edge 1+SETUP_CYCLES+HOLD_CYCLES+GAP_CYCLES.
- Frame period with a non-empty FIFO: 1+SETUP_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles (11 at defaults).
- Frames are sent in push order.
- DATA_OUT changes only on the IDLE pop edge. It holds the last byte indefinitely while idle, so it never changes while ENABLE_OUT=1.
- ENABLE_OUT is driven directly from a register (glitch-free) and produces exactly one rising edge per frame.

Decomposition:
- Package dataio_pkg:
  - FSM state encoding (IDLE/SETUP/STROBE/GAP)
  - field constants COORD_MSB=7, COORD_LSB=3, VALUE_MSB=2, VALUE_LSB=1, PARITY_BIT=0
  - byte-pack/parity function, shared with the receiver
- Sub-module tx_fifo:
  - synchronous FIFO of 7-bit entries with push, pop, full, empty and overflow
  - instantiated once
  - FSM, counter and output registers live in data_output_tx

Test Plan:
- Single push coord=5, value=2 at edge 0, defaults:
  - DATA_OUT=0x2D after edge 1.
  - ENABLE_OUT high after edges 3..6 only (4 cycles).
  - BUSY low after edge 11.
- Pack boundaries, one push each:
  - coord=31, value=3 -> 0xFF.
  - coord=0, value=0 -> 0x00.
  - coord=1, value=0 -> 0x09.
  - Every byte has an XOR of all bits equal to 0.
- Six back-to-back pushes (edges 0-5), FIFO_DEPTH=4:
  - Pushes 1-5 accepted; the push at edge 1 is a simultaneous push/pop.
  - The 6th is dropped; OVERFLOW=1 for exactly one cycle after edge 5; FULL=1 after edge 4.
  - Five frames out in order, rising edges of ENABLE_OUT 11 cycles apart.
- RESET asserted during STROBE:
  - ENABLE_OUT=0, DATA_OUT=0, BUSY=0, FULL=0 after that edge.
  - With 2 entries queued beforehand, no further ENABLE_OUT edges.
- Loopback into the dataInput receiver with random coord/value streams:
  - Receiver sees exactly one write per frame, with matching COORD/VALUE.
  - DATA_OUT is never seen changing while ENABLE_OUT=1.
- SETUP_CYCLES=1, HOLD_CYCLES=1, GAP_CYCLES=1 with a continuous push stream:
  - Period is 4 cycles.
  - ENABLE_OUT pulse is 1 cycle, with at least 2 low cycles between pulses.

Source files
------------

// File: rtl/dataio_pkg.sv
// Shared definitions for the 8-bit coordinate/value GPIO link:
// field positions, transmitter FSM states and the byte packer.
package dataio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } tx_state_t;

  localparam int COORD_MSB  = 7;
  localparam int COORD_LSB  = 3;
  localparam int VALUE_MSB  = 2;
  localparam int VALUE_LSB  = 1;
  localparam int PARITY_BIT = 0;
  localparam int ENTRY_W    = 7;

  // Even parity: the XOR of all eight bits of the packed byte is zero.
  function automatic logic [7:0] pack_byte(input logic [4:0] coord, input logic [1:0] value);
    logic [7:0] b;
    b = '0;
    b[COORD_MSB:COORD_LSB] = coord;
    b[VALUE_MSB:VALUE_LSB] = value;
    b[PARITY_BIT]          = ^b[7:1];
    return b;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO holding pending {coord, value} updates.
// Pushes while full are dropped and flagged with a one-cycle overflow pulse.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full;
  logic             r_overflow;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW:0]      w_count_next;

  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset so it can map onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_full     <= (w_count_next == (AW+1)'(DEPTH));
      r_overflow <= i_push & r_full;
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = (r_count == '0);
  assign o_overflow = r_overflow;

endmodule

// File: rtl/data_output_tx.sv
// GPIO-side transmitter: buffers (coord, value) updates and sends each one as a
// parity-protected byte with a setup / strobe / gap handshake on ENABLE_OUT.
module data_output_tx
  import dataio_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [4:0] COORD_IN,
  input  logic [1:0] VALUE_IN,
  input  logic       WRITE_IN,
  output logic       FULL,
  output logic       OVERFLOW,
  output logic       BUSY,
  output logic [7:0] DATA_OUT,
  output logic       ENABLE_OUT
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

  tx_state_t          r_state;
  tx_state_t          w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [7:0]         r_data;
  logic               r_enable;
  logic               w_pop;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_pop_data;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk       (CLOCK_50),
    .i_srst      (RESET),
    .i_push      (WRITE_IN),
    .i_push_data ({COORD_IN, VALUE_IN}),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_data),
    .o_full      (FULL),
    .o_empty     (w_empty),
    .o_overflow  (OVERFLOW)
  );

  // Each timed state counts down to zero, then reloads for the next state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_SETUP;
          w_cnt_next   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_STROBE;
          w_cnt_next   = HOLD_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state_next = ST_GAP;
          w_cnt_next   = GAP_LOAD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Strobe is registered from the next state so it is glitch-free and aligned with STROBE.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_enable <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_enable <= (w_state_next == ST_STROBE);
      if (w_pop) begin
        r_data <= pack_byte(w_pop_data[6:2], w_pop_data[1:0]);
      end
    end
  end

  assign BUSY       = (r_state != ST_IDLE) | ~w_empty;
  assign DATA_OUT   = r_data;
  assign ENABLE_OUT = r_enable;

endmodule

// File: tb/tb_data_output_tx.sv
// Scoreboard bench for data_output_tx: stimulus queues expected bytes, a
// receiver-like monitor pops them on every rising edge of ENABLE_OUT.
module tb_data_output_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] coord;
  logic [1:0] value;
  logic       wr;
  logic       full, ovf, busy, en;
  logic [7:0] data;

  logic [4:0] coord_f;
  logic [1:0] value_f;
  logic       wr_f;
  logic       full_f, ovf_f, busy_f, en_f;
  logic [7:0] data_f;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] sb[$];
  int         rise_cyc[$];
  int         rise_f[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_output_tx dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .COORD_IN  (coord),
    .VALUE_IN  (value),
    .WRITE_IN  (wr),
    .FULL      (full),
    .OVERFLOW  (ovf),
    .BUSY      (busy),
    .DATA_OUT  (data),
    .ENABLE_OUT(en)
  );

  data_output_tx #(
    .SETUP_CYCLES(1),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1)
  ) dut_f (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .COORD_IN  (coord_f),
    .VALUE_IN  (value_f),
    .WRITE_IN  (wr_f),
    .FULL      (full_f),
    .OVERFLOW  (ovf_f),
    .BUSY      (busy_f),
    .DATA_OUT  (data_f),
    .ENABLE_OUT(en_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && (busy || en); i++) tick();
    check("idle_timeout", busy, 1'b0);
    tick();
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic send_one(input logic [4:0] c, input logic [1:0] v, input logic [7:0] exp);
    coord = c; value = v; wr = 1'b1;
    sb.push_back(exp);
    tick();
    wr = 1'b0;
    tick();
    check("pack_data", data, exp);
    $display("pack coord=%0d value=%0d -> 0x%02h", c, v, data);
    wait_idle(30);
  endtask

  // Receiver model: one write per rising edge of ENABLE_OUT
  logic       en_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  always @(negedge clk) begin
    if (en && !en_prev) begin
      rise_cyc.push_back(cyc);
      check("frame_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        logic [7:0] exp;
        exp = sb.pop_front();
        check("frame_coord", data[7:3], exp[7:3]);
        check("frame_value", data[2:1], exp[2:1]);
        check("frame_parity", ^data, 1'b0);
        $display("frame at cycle %0d: data=0x%02h expected=0x%02h", cyc, data, exp);
      end
    end
    if (en && en_prev) check("data_stable", data, data_prev);
    en_prev   = en;
    data_prev = data;
  end

  logic en_f_prev = 1'b0;
  always @(negedge clk) begin
    if (en_f && !en_f_prev) rise_f.push_back(cyc);
    if (en_f) check("fast_pulse_width", en_f_prev, 1'b0);
    en_f_prev = en_f;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; coord = '0; value = '0;
    wr_f = 1'b0; coord_f = '0; value_f = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_data", data, 8'h00);
    check("rst_enable", en, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_overflow", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    $display("reset: data=0x%02h en=%0b full=%0b ovf=%0b busy=%0b", data, en, full, ovf, busy);
    tick();

    // Single push, exact timing
    coord = 5'd5; value = 2'd2; wr = 1'b1;
    sb.push_back(8'h2D);
    tick();
    wr = 1'b0;
    check("t1_busy_e0", busy, 1'b1);
    check("t1_data_e0", data, 8'h00);
    check("t1_en_e0", en, 1'b0);
    tick();
    check("t1_data_e1", data, 8'h2D);
    check("t1_en_e1", en, 1'b0);
    for (int k = 2; k <= 11; k++) begin
      tick();
      check("t1_enable", en, (k >= 3 && k <= 6));
      check("t1_busy", busy, (k < 11));
    end
    $display("single push: data=0x%02h busy=%0b after edge 11", data, busy);
    wait_idle(30);

    // Pack boundaries
    send_one(5'd31, 2'd3, 8'hFF);
    send_one(5'd0,  2'd0, 8'h00);
    send_one(5'd1,  2'd0, 8'h09);

    // Six back-to-back pushes, the sixth overflows
    rise_cyc.delete();
    begin
      logic [4:0] cs[6];
      logic [1:0] vs[6];
      logic [7:0] es[6];
      cs = '{5'd3, 5'd10, 5'd17, 5'd24, 5'd7, 5'd20};
      vs = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
      es = '{8'h1B, 8'h55, 8'h8E, 8'hC0, 8'h3A, 8'h00};
      for (int k = 0; k < 6; k++) begin
        coord = cs[k]; value = vs[k]; wr = 1'b1;
        if (k < 5) sb.push_back(es[k]);
        tick();
        check("burst_full", full, (k >= 4));
        check("burst_overflow", ovf, (k == 5));
        $display("burst push %0d: full=%0b overflow=%0b", k, full, ovf);
      end
      wr = 1'b0;
      tick();
      check("burst_overflow_pulse", ovf, 1'b0);
    end
    wait_idle(80);
    check("burst_frames", rise_cyc.size(), 5);
    for (int i = 1; i < rise_cyc.size(); i++)
      check("burst_period", rise_cyc[i] - rise_cyc[i-1], 11);

    // Reset during STROBE with two entries queued
    coord = 5'd9; value = 2'd3; wr = 1'b1; sb.push_back(8'h4E); tick();
    coord = 5'd1; value = 2'd1; sb.push_back(8'h0A); tick();
    coord = 5'd2; value = 2'd2; sb.push_back(8'h14); tick();
    wr = 1'b0;
    tick();
    check("pre_reset_strobe", en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_enable", en, 1'b0);
    check("midrst_data", data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_full", full, 1'b0);
    $display("reset mid-frame: en=%0b data=0x%02h busy=%0b", en, data, busy);
    sb.delete();
    begin
      int n0;
      n0 = rise_cyc.size();
      for (int i = 0; i < 40; i++) tick();
      check("no_frames_after_reset", rise_cyc.size(), n0);
    end

    // Random loopback stream
    for (int k = 0; k < 8; k++) begin
      logic [4:0] c;
      logic [1:0] v;
      c = 5'($urandom_range(0, 31));
      v = 2'($urandom_range(0, 3));
      for (int j = 0; j < 50 && full; j++) tick();
      coord = c; value = v; wr = 1'b1;
      sb.push_back({c, v, ^{c, v}});
      $display("random push coord=%0d value=%0d", c, v);
      tick();
      wr = 1'b0;
      for (int j = 0; j < int'($urandom_range(0, 12)); j++) tick();
    end
    wait_idle(200);

    // Minimum timing: continuous pushes into the 1/1/1 instance
    rise_f.delete();
    coord_f = 5'd12; value_f = 2'd1; wr_f = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    wr_f = 1'b0;
    for (int i = 0; i < 100 && busy_f; i++) tick();
    check("fast_idle", busy_f, 1'b0);
    check("fast_frames", rise_f.size(), 7);
    for (int i = 1; i < rise_f.size(); i++)
      check("fast_period", rise_f[i] - rise_f[i-1], 4);
    $display("fast instance: %0d frames", rise_f.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
